// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with a frame-aligned shadow register and leading-zero blanking.
// Latency: outputs update on the same edge the scan index advances; a load becomes visible at the next frame boundary.
// Backpressure: none; load is always accepted, and ena=0 freezes the scan and darkens the display.
module seg7_scan_mux #(
    parameter logic [15:0] SCAN_DIV = 16'd10_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    localparam logic [15:0] LP_LAST = SCAN_DIV - 16'd1;

    // Display word layout: [19:16] decimal points, [15:0] BCD nibbles.
    logic [15:0] r_pre;
    logic [1:0]  r_idx;
    logic [19:0] r_shadow;
    logic [19:0] r_display;
    logic        r_pending;
    logic [3:0]  r_digit_en;
    logic [6:0]  r_segments;
    logic        r_dp;
    logic        r_frame_start;

    logic        w_wrap;
    logic        w_boundary;
    logic [1:0]  w_idx_next;
    logic [19:0] w_disp_next;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_dp_sel;
    logic        w_dark;
    logic [6:0]  w_seg_dec;

    // BCD to segments; non-decimal nibbles render as a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;
        endcase
        return seg;
    endfunction

    // Next scan position and the segment pattern it will show; digit 0 of a new
    // frame is decoded from the value being copied into the display on that edge.
    always_comb begin
        w_wrap      = ena && (r_pre == LP_LAST);
        w_boundary  = w_wrap && (r_idx == 2'd3);
        w_idx_next  = w_wrap ? (r_idx + 2'd1) : r_idx;
        w_disp_next = (w_boundary && r_pending) ? r_shadow : r_display;
        w_dark      = (r_digit_en == 4'b0000);
        w_nib       = 4'h0;
        w_blank     = 1'b0;
        w_dp_sel    = 1'b0;
        case (w_idx_next)
            2'd0: begin
                w_nib    = w_disp_next[3:0];
                w_blank  = 1'b0;
                w_dp_sel = w_disp_next[16];
            end
            2'd1: begin
                w_nib    = w_disp_next[7:4];
                w_blank  = blank_lz && (w_disp_next[15:4] == 12'h000);
                w_dp_sel = w_disp_next[17];
            end
            2'd2: begin
                w_nib    = w_disp_next[11:8];
                w_blank  = blank_lz && (w_disp_next[15:8] == 8'h00);
                w_dp_sel = w_disp_next[18];
            end
            default: begin
                w_nib    = w_disp_next[15:12];
                w_blank  = blank_lz && (w_disp_next[15:12] == 4'h0);
                w_dp_sel = w_disp_next[19];
            end
        endcase
        w_seg_dec = w_blank ? 7'h00 : f_decode(w_nib);
    end

    // Prescaler and scan index run only while enabled and hold their value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= 16'd0;
            r_idx <= 2'd0;
        end else if (ena) begin
            if (w_wrap) begin
                r_pre <= 16'd0;
                r_idx <= w_idx_next;
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    // Shadow capture on load; transfer to the display only at a frame boundary.
    // A load on the boundary edge itself stays pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= 20'd0;
            r_display <= 20'd0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= {dp_in, bcd_in};
            end
            if (w_boundary && r_pending) begin
                r_display <= r_shadow;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Output registers: refresh on index advance or when returning from a dark period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_en    <= 4'b0001;
            r_segments    <= 7'h3F;
            r_dp          <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!ena) begin
            r_digit_en    <= 4'b0000;
            r_segments    <= 7'h00;
            r_dp          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_wrap || w_dark) begin
                r_digit_en <= 4'b0001 << w_idx_next;
                r_segments <= w_seg_dec;
                r_dp       <= w_dp_sel;
            end
        end
    end

    assign segments    = r_segments;
    assign dp          = r_dp;
    assign digit_en    = r_digit_en;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_mux #(.SCAN_DIV(16'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .segments    (segments),
        .dp          (dp),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    // seg is {digit3, digit2, digit1, digit0}
    typedef struct packed {
        logic            blank;
        logic [15:0]     bcd;
        logic [3:0]      dpm;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs [9];
    vec_t v1111;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input string tag);
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (frame_start !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s frame_start timeout: got 0, expected 1 within 40 cycles", tag);
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] p);
        bcd_in = b;
        dp_in  = p;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        bcd_in = 16'hFFFF;
        dp_in  = 4'hF;
    endtask

    // Called on the sample point right after a frame boundary; walks all four slots.
    task automatic check_frame(input vec_t v, input string tag);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] en_exp;
            en_exp = 4'b0001 << d;
            chk($sformatf("%s d%0d digit_en", tag, d), 32'(digit_en), 32'(en_exp));
            chk($sformatf("%s d%0d segments", tag, d), 32'(segments), 32'(v.seg[d]));
            chk($sformatf("%s d%0d dp", tag, d), 32'(dp), 32'(v.dpm[d]));
            tick(4);
        end
    endtask

    initial begin
        //               blank  bcd       dp       d3     d2     d1     d0
        vecs[0] = '{1'b0, 16'h1234, 4'b0100, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{1'b1, 16'h0070, 4'b0000, {7'h00, 7'h00, 7'h07, 7'h3F}};
        vecs[2] = '{1'b1, 16'h0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{1'b0, 16'h00A9, 4'b0000, {7'h3F, 7'h3F, 7'h40, 7'h6F}};
        vecs[4] = '{1'b1, 16'h00A9, 4'b1010, {7'h00, 7'h00, 7'h40, 7'h6F}};
        vecs[5] = '{1'b0, 16'h5678, 4'b0001, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
        vecs[6] = '{1'b0, 16'h9FB0, 4'b0000, {7'h6F, 7'h40, 7'h40, 7'h3F}};
        vecs[7] = '{1'b1, 16'h0300, 4'b0000, {7'h00, 7'h4F, 7'h3F, 7'h3F}};
        vecs[8] = '{1'b1, 16'hA000, 4'b0000, {7'h40, 7'h3F, 7'h3F, 7'h3F}};
        v1111   = '{1'b1, 16'h1111, 4'b0000, {7'h06, 7'h06, 7'h06, 7'h06}};

        // Reset values
        #2 rst_n = 1'b0;
        tick(2);
        chk("reset digit_en", 32'(digit_en), 32'h1);
        chk("reset segments", 32'(segments), 32'h3F);
        chk("reset dp", 32'(dp), 32'h0);
        chk("reset frame_start", 32'(frame_start), 32'h0);
        rst_n = 1'b1;

        // Free-running rotation with zero display
        for (int c = 1; c <= 36; c++) begin
            logic [3:0] en_exp;
            tick(1);
            en_exp = 4'b0001 << ((c / 4) % 4);
            chk($sformatf("rot c%0d digit_en", c), 32'(digit_en), 32'(en_exp));
            chk($sformatf("rot c%0d frame_start", c), 32'(frame_start), ((c % 16) == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rot c%0d segments", c), 32'(segments), 32'h3F);
        end

        // Table: load mid-frame, then the following frame shows the vector
        for (int i = 0; i < 9; i++) begin
            wait_fs($sformatf("vec%0d pre", i));
            tick(6);
            blank_lz = vecs[i].blank;
            do_load(vecs[i].bcd, vecs[i].dpm);
            wait_fs($sformatf("vec%0d", i));
            check_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-frame load leaves the current frame untouched
        tick(5);
        do_load(16'h1234, 4'b0100);
        tick(2);
        chk("midload d2 digit_en", 32'(digit_en), 32'h4);
        chk("midload d2 segments", 32'(segments), 32'h3F);
        tick(4);
        chk("midload d3 digit_en", 32'(digit_en), 32'h8);
        chk("midload d3 segments", 32'(segments), 32'h40);
        tick(4);
        chk("midload frame_start", 32'(frame_start), 32'h1);
        check_frame(vecs[0], "midload new");

        // Last mid-frame load wins; a load on the boundary edge waits one more frame
        tick(5);
        do_load(16'h0070, 4'b0000);
        tick(4);
        do_load(16'h5678, 4'b0001);
        tick(4);
        bcd_in = 16'h1111;
        dp_in  = 4'b0000;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        chk("bndload frame_start", 32'(frame_start), 32'h1);
        check_frame(vecs[5], "bndload prior");
        check_frame(v1111, "bndload next");

        // ena low for 10 cycles in the middle of slot 1
        tick(5);
        ena = 1'b0;
        for (int g = 0; g < 10; g++) begin
            tick(1);
            chk($sformatf("gap%0d digit_en", g), 32'(digit_en), 32'h0);
            chk($sformatf("gap%0d segments", g), 32'(segments), 32'h0);
            chk($sformatf("gap%0d dp", g), 32'(dp), 32'h0);
        end
        ena = 1'b1;
        tick(1);
        chk("resume digit_en", 32'(digit_en), 32'h2);
        chk("resume segments", 32'(segments), 32'h06);
        tick(1);
        chk("resume hold digit_en", 32'(digit_en), 32'h2);
        tick(1);
        chk("resume advance digit_en", 32'(digit_en), 32'h4);
        tick(4);
        chk("resume d3 digit_en", 32'(digit_en), 32'h8);
        tick(4);
        chk("resume frame digit_en", 32'(digit_en), 32'h1);
        chk("resume frame_start", 32'(frame_start), 32'h1);

        // Asynchronous reset pulse mid-frame
        tick(6);
        rst_n = 1'b0;
        #1;
        chk("areset digit_en", 32'(digit_en), 32'h1);
        chk("areset segments", 32'(segments), 32'h3F);
        chk("areset dp", 32'(dp), 32'h0);
        chk("areset frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk("post-reset hold digit_en", 32'(digit_en), 32'h1);
        tick(1);
        chk("post-reset d1 digit_en", 32'(digit_en), 32'h2);
        chk("post-reset d1 blanked", 32'(segments), 32'h00);
        tick(4);
        chk("post-reset d2 digit_en", 32'(digit_en), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Four-digit time-multiplexed seven-segment driver that consumes the BCD digits produced by the seconds/digit counter stage and drives a common-cathode multi-digit display. It latches a 16-bit BCD word, decodes each nibble to segments internally, and scans the digits one at a time at a parameterised rate. New values are applied only at frame boundaries so a frame never shows a mix of old and new digits.

## Interface
- SCAN_DIV, default 16'd10_000: clock cycles per digit slot (1 kHz per digit at 10 MHz); legal range 2..65535
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  design enable; low freezes scanning and darkens display
- bcd_in  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- dp_in  input  4  decimal point per digit, bit n = digit n
- load  input  1  one-cycle strobe: capture bcd_in/dp_in into shadow register
- blank_lz  input  1  1 = suppress leading zeros
- segments  output  7  active-high segments, bit0 = a ... bit6 = g
- dp  output  1  active-high decimal point of selected digit
- digit_en  output  4  one-hot active-high digit select
- frame_start  output  1  one-cycle pulse when the scan enters digit 0

## Operation
- Registers: 16-bit prescaler, 2-bit scan index, shadow (16+4 bits), display (16+4 bits), pending flag, all outputs registered.
- load=1: shadow <= {dp_in, bcd_in}, pending <= 1. Accepted regardless of ena. Multiple loads inside one frame: last wins.
- Prescaler counts 0..SCAN_DIV-1 while ena=1; on reaching SCAN_DIV-1 it wraps to 0 and index advances 0->1->2->3->0.
- Frame boundary (index 3->0): if pending, display <= shadow and pending <= 0; frame_start pulses. load in the same cycle as the boundary: display takes the old shadow, new value stays pending for the next frame.
- Decode (hex, bit0=a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; nibbles A-F show "-" (40).
- Leading-zero blanking (blank_lz=1): digit n (n=3,2,1) shows segments 00 if its nibble and all higher nibbles are 0. Digit 0 is never blanked. The dp bit is always shown per display dp bits, blanked or not.
- ena=0: prescaler and index hold, digit_en <= 0000, segments <= 00, dp <= 0, frame_start <= 0. On ena return, outputs for the held index are restored on the next edge and the prescaler resumes from its held value.

## Timing
- Reset (async assert, sync-to-clock release inherent): prescaler 0, index 0, shadow 0, display 0, pending 0; digit_en=0001, segments=3F, dp=0, frame_start=0.
- Outputs change only on the edge where the index advances (or ena toggles). digit_en/segments/dp for the new index appear in the same registers on that edge. There is no extra pipeline cycle.
- On the boundary edge, segments for digit 0 are decoded from the newly copied display value.
- Each digit is held for exactly SCAN_DIV cycles, and a frame lasts 4*SCAN_DIV cycles while ena=1.
- load-to-visible latency: up to one full frame plus remaining slot, at most 4*SCAN_DIV cycles from the load edge to the first frame_start using it.
- blank_lz is sampled at each output update, not latched with load.

## Test plan
- Reset, SCAN_DIV=4: hold rst_n=0 -> digit_en=0001, segments=3F, dp=0. Release, no load -> after 4 cycles digit_en=0010, and the rotation repeats 0001/0010/0100/1000 every 4 cycles with frame_start pulsing every 16.
- load bcd_in=16'h1234, dp_in=4'b0100 mid-frame -> the current frame is unchanged. From the next frame_start, digits 0..3 show 4F(3 on dig1? no: dig0=66 "4", dig1=4F "3", dig2=5B "2", dig3=06 "1"). dp=1 only while digit_en=0100.
- blank_lz=1, load 16'h0070 -> dig3 00, dig2 00, dig1 07, dig0 3F. Load 16'h0000 -> only dig0 shows 3F.
- load 16'h00A9 -> dig1 shows 40, dig0 shows 6F. With blank_lz=1, dig3/dig2 are blank.
- load 16'h1111 on the exact boundary cycle, then no further load -> the frame that starts shows the prior value. The following frame shows 06 on all digits.
- ena=0 for 10 cycles mid-slot, then ena=1 -> digit_en=0000 during the gap. The same digit returns and completes its remaining slot count. A rst_n pulse mid-frame returns immediately to the reset values.
